writeback_stage: RTL and testbench
==================================

# writeback_stage

Parametrised write-back stage for the pipelined RISC-V core, replacing the purely combinational result select. It owns the MEM/WB pipeline register with stall/flush, extracts and sign/zero-extends sub-word load data, and selects among four result sources. It also gates the register-file write, flags misaligned loads, and keeps a retired-instruction counter. It sits between the memory stage and the register file / forwarding network.

## Interface
- XLEN, 32, datapath width; legal values 32 or 64
- REG_AW, 5, register address width
- CNT_W, 64, retired-instruction counter width
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-low
- StallW  in  1  hold W-stage register contents
- FlushW  in  1  load a bubble into W instead of the M-stage instruction
- ValidM  in  1  M-stage slot holds a real instruction
- RegWriteM  in  1  instruction writes rd
- RdM  in  REG_AW  destination register
- ResultSrcM  in  2  result source: 00 ALU, 01 load, 10 PC+4, 11 immediate (LUI)
- Funct3M  in  3  load size/sign encoding
- ALUResultM, ReadDataM, PCPlus4M, ImmExtM  in  XLEN each  datapath operands; ReadDataM is the full aligned memory word
- ResultW  out  XLEN  value written to rd / forwarded
- RdW  out  REG_AW  registered destination
- RegWriteW  out  1  gated register-file write enable
- ValidW  out  1  W slot valid
- LoadMisalignW  out  1  current W load is misaligned
- InstRetW  out  CNT_W  retired-instruction count

## Operation
- Pipeline register (all M inputs), evaluated each rising edge:
  - rst=0: all registered fields 0, InstRetW 0.
  - else FlushW=1: ValidW and RegWrite field <= 0, other fields <= 0. Flush wins over stall.
  - else StallW=1: hold.
  - else capture the M inputs.
- Load extraction, combinational on registered data:
  - Offset off = ALUResult[1:0] for XLEN=32, ALUResult[2:0] for XLEN=64.
  - funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - XLEN=64 adds 011 LD and 110 LWU. On XLEN=32 these are illegal and treated as LW.
  - Extracted field = ReadData >> (8*off), then sign- or zero-extended to XLEN.
- Misalignment: LoadMisalignW = ValidW & ResultSrc==01 & (halfword with off[0]≠0 | word with off[1:0]≠0 | doubleword with off≠0).
- Result mux, by ResultSrc:
  - 00: ALU result.
  - 01: extracted load data; 0 when misaligned.
  - 10: PC+4.
  - 11: immediate.
- Write gating: RegWriteW = RegWrite field & ValidW & (RdW≠0) & ~LoadMisalignW.
- Retire counter:
  - Increments by 1 on each edge where ValidW & ~StallW & ~LoadMisalignW & rst=1.
  - Wraps modulo 2^CNT_W; no saturation.

## Timing
- Latency: an M-stage instruction is visible on ValidW/ResultW/RdW one cycle after the capture edge.
- ResultW, RegWriteW and LoadMisalignW are combinational from W registers only; there is no M-to-W combinational path.
- Instruction held by StallW for k cycles:
  - ResultW/RegWriteW stay stable for k+1 cycles, so the register file rewrites the same value.
  - The counter increments exactly once, on the edge where StallW=0.
- FlushW with ValidW=1 at the same edge: the current W instruction still retires (counted if StallW=0). Only the incoming instruction is squashed.
- Reset mid-stall or mid-flush: reset dominates; all outputs 0 the next cycle.
- All outputs are 0 after reset (ResultW=0 because ResultSrc=00 and ALU field=0).

## Structure
- Shared package riscv_wb_pkg:
  - ResultSrc encodings RES_ALU/RES_LOAD/RES_PC4/RES_IMM.
  - Load funct3 constants F3_LB…F3_LWU.
- Sub-module load_align: purely combinational; inputs ReadData, offset, funct3; outputs extended data and the misalign flag.
- The stage holds the register, result mux, write gating and counter.

## Test plan
- Reset: hold rst=0 for 2 cycles with nonzero M inputs → all outputs 0, InstRetW=0. Release → first valid capture appears next cycle.
- Load extraction, XLEN=32, ReadData=0x8899AABB:
  - LB with off=1 → 0xFFFFFFAA.
  - LBU with off=3 → 0x00000088.
  - LH with off=2 → 0xFFFF8899.
  - LW with off=0 → 0x8899AABB.
- Misaligned LW with off=2, RdM=5 → LoadMisalignW=1, RegWriteW=0, ResultW=0, counter unchanged.
- Stall: capture ALU op (ALUResult=0x1234, Rd=3), then StallW=1 for 3 cycles → ResultW=0x1234 stable for 4 cycles, InstRetW increments by 1 total.
- Flush and x0:
  - FlushW=1 with a valid M instruction → ValidW=0 and RegWriteW=0 next cycle.
  - Separately, an RdM=0 write → RegWriteW=0, but the instruction is counted.
- Wrap and XLEN=64:
  - CNT_W=4, retire 17 instructions → InstRetW=1.
  - XLEN=64, LWU with off=4, ReadData=0xF0000001_00000000 → ResultW=0x00000000F0000001.

Source files
------------

// File: rtl/writeback_stage_pkg.sv
// Shared definitions for the write-back stage.
// Provides the result-source encoding used by the W-stage result mux and
// the load funct3 codes decoded by the load aligner.
package riscv_wb_pkg;

    typedef enum logic [1:0] {
        RES_ALU  = 2'b00,
        RES_LOAD = 2'b01,
        RES_PC4  = 2'b10,
        RES_IMM  = 2'b11
    } result_src_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

endpackage

// File: rtl/writeback_stage_if.sv
// MEM/WB boundary bundle.
// master: memory stage / pipeline control side (drives M-stage fields and
//         StallW/FlushW, observes W-stage results).
// slave : write-back stage (consumes M-stage fields, drives W-stage results).
interface writeback_stage_if #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 64
);
    logic              StallW;
    logic              FlushW;
    logic              ValidM;
    logic              RegWriteM;
    logic [REG_AW-1:0] RdM;
    logic [1:0]        ResultSrcM;
    logic [2:0]        Funct3M;
    logic [XLEN-1:0]   ALUResultM;
    logic [XLEN-1:0]   ReadDataM;
    logic [XLEN-1:0]   PCPlus4M;
    logic [XLEN-1:0]   ImmExtM;

    logic [XLEN-1:0]   ResultW;
    logic [REG_AW-1:0] RdW;
    logic              RegWriteW;
    logic              ValidW;
    logic              LoadMisalignW;
    logic [CNT_W-1:0]  InstRetW;

    modport master (
        output StallW, FlushW, ValidM, RegWriteM, RdM, ResultSrcM, Funct3M,
               ALUResultM, ReadDataM, PCPlus4M, ImmExtM,
        input  ResultW, RdW, RegWriteW, ValidW, LoadMisalignW, InstRetW
    );

    modport slave (
        input  StallW, FlushW, ValidM, RegWriteM, RdM, ResultSrcM, Funct3M,
               ALUResultM, ReadDataM, PCPlus4M, ImmExtM,
        output ResultW, RdW, RegWriteW, ValidW, LoadMisalignW, InstRetW
    );
endinterface

// File: rtl/writeback_stage_load_align.sv
// Combinational sub-word load extraction.
// Inputs : read_data (full aligned memory word), offset (byte offset within
//          the word), funct3 (load size/sign).
// Outputs: load_data (field shifted down and sign/zero-extended to XLEN),
//          misalign (access not naturally aligned for its size; not gated
//          with valid or result source).
module load_align
    import riscv_wb_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned OFF_W = (XLEN == 64) ? 3 : 2
) (
    input  logic [XLEN-1:0]  read_data,
    input  logic [OFF_W-1:0] offset,
    input  logic [2:0]       funct3,
    output logic [XLEN-1:0]  load_data,
    output logic             misalign
);
    logic [XLEN-1:0] shifted;

    assign shifted = read_data >> {offset, 3'b000};

    // Sized casts do the extension: a signed operand sign-extends, an
    // unsigned one zero-extends, and XLEN'(32-bit) is an identity on RV32.
    always_comb begin
        load_data = shifted;
        misalign  = 1'b0;
        case (funct3)
            F3_LB:  load_data = XLEN'($signed(shifted[7:0]));
            F3_LBU: load_data = XLEN'(shifted[7:0]);
            F3_LH: begin
                load_data = XLEN'($signed(shifted[15:0]));
                misalign  = offset[0];
            end
            F3_LHU: begin
                load_data = XLEN'(shifted[15:0]);
                misalign  = offset[0];
            end
            F3_LW: begin
                load_data = XLEN'($signed(shifted[31:0]));
                misalign  = (offset[1:0] != 2'b00);
            end
            // RV32 has no LD/LWU; they decode as LW there.
            F3_LD: begin
                if (XLEN == 64) begin
                    load_data = shifted;
                    misalign  = (offset != '0);
                end else begin
                    load_data = XLEN'($signed(shifted[31:0]));
                    misalign  = (offset[1:0] != 2'b00);
                end
            end
            F3_LWU: begin
                if (XLEN == 64) begin
                    load_data = XLEN'(shifted[31:0]);
                end else begin
                    load_data = XLEN'($signed(shifted[31:0]));
                end
                misalign = (offset[1:0] != 2'b00);
            end
            default: begin
                load_data = shifted;
                misalign  = 1'b0;
            end
        endcase
    end
endmodule

// File: rtl/writeback_stage.sv
// Write-back stage: MEM/WB pipeline register with stall/flush, load data
// extraction, four-way result select, register-file write gating,
// misaligned-load flag and retired-instruction counter.
// Ports: clk (rising edge), rst (synchronous, active-low), bus (slave side
// of writeback_stage_if carrying the M-stage fields, StallW/FlushW and the
// W-stage results ResultW/RdW/RegWriteW/ValidW/LoadMisalignW/InstRetW).
module writeback_stage
    import riscv_wb_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 64
) (
    input  logic              clk,
    input  logic              rst,
    writeback_stage_if.slave  bus
);
    localparam int unsigned OFF_W = (XLEN == 64) ? 3 : 2;

    logic              valid_q,      valid_d;
    logic              reg_write_q,  reg_write_d;
    logic [REG_AW-1:0] rd_q,         rd_d;
    result_src_e       result_src_q, result_src_d;
    logic [2:0]        funct3_q,     funct3_d;
    logic [XLEN-1:0]   alu_q,        alu_d;
    logic [XLEN-1:0]   rdata_q,      rdata_d;
    logic [XLEN-1:0]   pc4_q,        pc4_d;
    logic [XLEN-1:0]   imm_q,        imm_d;
    logic [CNT_W-1:0]  inst_ret_q,   inst_ret_d;

    logic [XLEN-1:0]   load_data;
    logic              align_misalign;
    logic              load_misalign;
    logic              retire;
    logic [XLEN-1:0]   result;

    // Retirement looks only at the instruction already in W, so a flush
    // on the same edge squashes the incoming one but still counts this one.
    assign retire = valid_q & ~bus.StallW & ~load_misalign;

    always_comb begin
        valid_d      = valid_q;
        reg_write_d  = reg_write_q;
        rd_d         = rd_q;
        result_src_d = result_src_q;
        funct3_d     = funct3_q;
        alu_d        = alu_q;
        rdata_d      = rdata_q;
        pc4_d        = pc4_q;
        imm_d        = imm_q;
        inst_ret_d   = inst_ret_q + CNT_W'(retire);
        if (bus.FlushW) begin
            valid_d      = 1'b0;
            reg_write_d  = 1'b0;
            rd_d         = '0;
            result_src_d = RES_ALU;
            funct3_d     = '0;
            alu_d        = '0;
            rdata_d      = '0;
            pc4_d        = '0;
            imm_d        = '0;
        end else if (!bus.StallW) begin
            valid_d      = bus.ValidM;
            reg_write_d  = bus.RegWriteM;
            rd_d         = bus.RdM;
            result_src_d = result_src_e'(bus.ResultSrcM);
            funct3_d     = bus.Funct3M;
            alu_d        = bus.ALUResultM;
            rdata_d      = bus.ReadDataM;
            pc4_d        = bus.PCPlus4M;
            imm_d        = bus.ImmExtM;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q      <= 1'b0;
            reg_write_q  <= 1'b0;
            rd_q         <= '0;
            result_src_q <= RES_ALU;
            funct3_q     <= '0;
            alu_q        <= '0;
            rdata_q      <= '0;
            pc4_q        <= '0;
            imm_q        <= '0;
            inst_ret_q   <= '0;
        end else begin
            valid_q      <= valid_d;
            reg_write_q  <= reg_write_d;
            rd_q         <= rd_d;
            result_src_q <= result_src_d;
            funct3_q     <= funct3_d;
            alu_q        <= alu_d;
            rdata_q      <= rdata_d;
            pc4_q        <= pc4_d;
            imm_q        <= imm_d;
            inst_ret_q   <= inst_ret_d;
        end
    end

    load_align #(
        .XLEN  (XLEN),
        .OFF_W (OFF_W)
    ) u_load_align (
        .read_data (rdata_q),
        .offset    (alu_q[OFF_W-1:0]),
        .funct3    (funct3_q),
        .load_data (load_data),
        .misalign  (align_misalign)
    );

    assign load_misalign = valid_q & (result_src_q == RES_LOAD) & align_misalign;

    always_comb begin
        result = alu_q;
        case (result_src_q)
            RES_ALU:  result = alu_q;
            RES_LOAD: result = load_misalign ? '0 : load_data;
            RES_PC4:  result = pc4_q;
            RES_IMM:  result = imm_q;
            default:  result = alu_q;
        endcase
    end

    assign bus.ResultW       = result;
    assign bus.RdW           = rd_q;
    assign bus.ValidW        = valid_q;
    assign bus.LoadMisalignW = load_misalign;
    assign bus.RegWriteW     = reg_write_q & valid_q & (rd_q != '0) & ~load_misalign;
    assign bus.InstRetW      = inst_ret_q;
endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage.
// dut32: XLEN=32 with a 4-bit retire counter (exercises wrap-around).
// dut64: XLEN=64 for the doubleword-only load encodings.
module tb_writeback_stage;
    import riscv_wb_pkg::*;

    typedef struct packed {
        logic        valid;
        logic [4:0]  rd;
        logic        rw;
        logic [31:0] res;
        logic        mis;
    } exp_t;

    // Starts high so the first negedge (scoreboard step) precedes the first
    // posedge (DUT capture).
    logic clk = 1'b1;
    logic rst;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    exp_t     exp_q[$];
    exp_t     cur;
    logic [3:0] cnt_model;
    bit       armed = 1'b0;

    writeback_stage_if #(.XLEN(32), .REG_AW(5), .CNT_W(4))  b32();
    writeback_stage_if #(.XLEN(64), .REG_AW(5), .CNT_W(64)) b64();

    writeback_stage #(.XLEN(32), .REG_AW(5), .CNT_W(4)) dut32 (
        .clk (clk),
        .rst (rst),
        .bus (b32)
    );

    writeback_stage #(.XLEN(64), .REG_AW(5), .CNT_W(64)) dut64 (
        .clk (clk),
        .rst (rst),
        .bus (b64)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Scoreboard step: the W register state expected for this cycle is
    // compared, then the model advances over the coming edge.
    always @(negedge clk) begin
        exp_t nx;
        if (armed) begin
            check_eq("ValidW",        64'(b32.ValidW),        64'(cur.valid));
            check_eq("RdW",           64'(b32.RdW),           64'(cur.rd));
            check_eq("RegWriteW",     64'(b32.RegWriteW),     64'(cur.rw));
            check_eq("ResultW",       64'(b32.ResultW),       64'(cur.res));
            check_eq("LoadMisalignW", 64'(b32.LoadMisalignW), 64'(cur.mis));
            check_eq("InstRetW",      64'(b32.InstRetW),      64'(cnt_model));
        end
        nx = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
        if (!rst) cnt_model = '0;
        else if (cur.valid && !b32.StallW && !cur.mis) cnt_model = cnt_model + 4'd1;
        if (!rst)            cur = '0;
        else if (b32.FlushW) cur = '0;
        else if (!b32.StallW) cur = nx;
        armed = 1'b1;
    end

    task automatic send(input logic r, input logic st, input logic fl, input logic v,
                        input logic rw, input logic [4:0] rd, input logic [1:0] src,
                        input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] rdata,
                        input logic [31:0] pc4, input logic [31:0] imm,
                        input logic [31:0] eres, input logic emis);
        exp_t e;
        rst            = r;
        b32.StallW     = st;
        b32.FlushW     = fl;
        b32.ValidM     = v;
        b32.RegWriteM  = rw;
        b32.RdM        = rd;
        b32.ResultSrcM = src;
        b32.Funct3M    = f3;
        b32.ALUResultM = alu;
        b32.ReadDataM  = rdata;
        b32.PCPlus4M   = pc4;
        b32.ImmExtM    = imm;
        e.valid = v;
        e.rd    = v ? rd : 5'd0;
        e.rw    = rw & v & (rd != 5'd0) & ~emis;
        e.res   = eres;
        e.mis   = emis & v;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic alu_op(input logic [4:0] rd, input logic [31:0] val);
        send(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, rd, RES_ALU, 3'd0, val, 32'h0, 32'h0, 32'h0, val, 1'b0);
    endtask

    task automatic load_op(input logic [4:0] rd, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] data, input logic [31:0] eres, input logic emis);
        send(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, rd, RES_LOAD, f3, addr, data, 32'h0, 32'h0, eres, emis);
    endtask

    task automatic bubble();
        send(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, RES_ALU, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    endtask

    localparam logic [31:0] RD32 = 32'h8899AABB;

    initial begin
        b64.StallW = 1'b0; b64.FlushW = 1'b0; b64.ValidM = 1'b0; b64.RegWriteM = 1'b0;
        b64.RdM = '0; b64.ResultSrcM = RES_ALU; b64.Funct3M = '0;
        b64.ALUResultM = '0; b64.ReadDataM = '0; b64.PCPlus4M = '0; b64.ImmExtM = '0;

        // Reset held two cycles with live M inputs.
        send(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd7, RES_IMM, 3'd0, 32'h55, RD32, 32'h8, 32'h99, 32'h0, 1'b0);
        send(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd7, RES_IMM, 3'd0, 32'h55, RD32, 32'h8, 32'h99, 32'h0, 1'b0);

        // Result sources and load extraction.
        alu_op(5'd1, 32'hDEAD0001);
        load_op(5'd2, F3_LB,  32'h1001, RD32, 32'hFFFFFFAA, 1'b0);
        load_op(5'd2, F3_LBU, 32'h1003, RD32, 32'h00000088, 1'b0);
        load_op(5'd2, F3_LH,  32'h1002, RD32, 32'hFFFF8899, 1'b0);
        load_op(5'd2, F3_LW,  32'h1000, RD32, 32'h8899AABB, 1'b0);
        load_op(5'd2, F3_LHU, 32'h1000, RD32, 32'h0000AABB, 1'b0);
        load_op(5'd2, F3_LB,  32'h1000, RD32, 32'hFFFFFFBB, 1'b0);
        send(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd6, RES_PC4, 3'd0, 32'h1, 32'h0, 32'h104, 32'h0, 32'h104, 1'b0);
        send(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd6, RES_IMM, 3'd0, 32'h1, 32'h0, 32'h0, 32'hABCDE000, 32'hABCDE000, 1'b0);

        // Misaligned loads: no write, zero result, not counted.
        load_op(5'd5, F3_LW, 32'h1002, RD32, 32'h0, 1'b1);
        load_op(5'd5, F3_LH, 32'h1001, RD32, 32'h0, 1'b1);
        bubble();

        // Stall for three cycles behind an ALU op.
        alu_op(5'd3, 32'h1234);
        for (int i = 0; i < 3; i++)
            send(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd9, RES_ALU, 3'd0, 32'hBAD, 32'h0, 32'h0, 32'h0, 32'hBAD, 1'b0);
        alu_op(5'd4, 32'h5678);

        // Flush squashes the incoming op; the one in W still retires.
        send(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 5'd4, RES_ALU, 3'd0, 32'h99, 32'h0, 32'h0, 32'h0, 32'h99, 1'b0);
        alu_op(5'd8, 32'hCAFE);
        // Flush and stall together: flush wins.
        send(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 5'd4, RES_ALU, 3'd0, 32'h98, 32'h0, 32'h0, 32'h0, 32'h98, 1'b0);

        // Write to x0: no register write, still retires.
        alu_op(5'd0, 32'h77);
        bubble();

        // Reset asserted while stalling.
        alu_op(5'd10, 32'hAAAA);
        send(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd11, RES_ALU, 3'd0, 32'hBBBB, 32'h0, 32'h0, 32'h0, 32'hBBBB, 1'b0);

        // 17 retirements on a 4-bit counter from zero.
        for (int i = 0; i < 17; i++)
            alu_op(5'(i + 1), 32'(i * 3 + 1));
        bubble();
        check_eq("wrap_InstRetW", 64'(b32.InstRetW), 64'd1);

        // XLEN=64 load encodings.
        b64.ValidM = 1'b1; b64.RegWriteM = 1'b1; b64.RdM = 5'd9; b64.ResultSrcM = RES_LOAD;
        b64.Funct3M = F3_LWU; b64.ALUResultM = 64'h4; b64.ReadDataM = 64'hF0000001_00000000;
        bubble();
        check_eq("x64_LWU_ResultW",   b64.ResultW, 64'h00000000F0000001);
        check_eq("x64_LWU_RegWriteW", 64'(b64.RegWriteW), 64'd1);
        check_eq("x64_LWU_Misalign",  64'(b64.LoadMisalignW), 64'd0);
        b64.Funct3M = F3_LW; b64.ReadDataM = 64'h80000000_00000000;
        bubble();
        check_eq("x64_LW_ResultW", b64.ResultW, 64'hFFFFFFFF80000000);
        b64.Funct3M = F3_LD; b64.ALUResultM = 64'h0; b64.ReadDataM = 64'h01234567_89ABCDEF;
        bubble();
        check_eq("x64_LD_ResultW", b64.ResultW, 64'h01234567_89ABCDEF);
        b64.ALUResultM = 64'h4;
        bubble();
        check_eq("x64_LD_Misalign",  64'(b64.LoadMisalignW), 64'd1);
        check_eq("x64_LD_RegWriteW", 64'(b64.RegWriteW), 64'd0);
        check_eq("x64_LD_ResultW0",  b64.ResultW, 64'h0);
        b64.ValidM = 1'b0;

        bubble();
        bubble();
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
